// File: rtl/booth_mult_sched_pkg.sv
// Shared definitions for the Booth radix-4 multiplier scheduler.
// Holds operand/product widths, the partial-product count, the Booth
// digit encoding, a Booth triple decoder and the 4-row carry-save
// reduction tree (four partial-product rows plus the sign-bit row).
package booth_mult_sched_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned PP_N   = 4;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } booth_digit_e;

    typedef struct packed {
        logic [PROD_W-1:0] sum;
        logic [PROD_W-1:0] carry;   // weight is 2x: consumer adds carry << 1
    } csa_t;

    // Triple is {b[2j+1], b[2j], b[2j-1]}.
    function automatic booth_digit_e booth_decode(input logic [2:0] t);
        booth_digit_e d;
        case (t)
            3'b001, 3'b010: d = P1;
            3'b011:         d = P2;
            3'b100:         d = M2;
            3'b101, 3'b110: d = M1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

    // Reduces r0+r1+r2+r3+sgn (mod 2^PROD_W) to sum + (carry << 1)
    // using three chained 3:2 compressors.
    function automatic csa_t csa4_reduce(
        input logic [PROD_W-1:0] r0,
        input logic [PROD_W-1:0] r1,
        input logic [PROD_W-1:0] r2,
        input logic [PROD_W-1:0] r3,
        input logic [PROD_W-1:0] sgn
    );
        logic [PROD_W-1:0] s0, c0, s1, c1, x1, x2;
        csa_t res;
        s0        = r0 ^ r1 ^ r2;
        c0        = (r0 & r1) | (r0 & r2) | (r1 & r2);
        x1        = c0 << 1;
        s1        = s0 ^ x1 ^ r3;
        c1        = (s0 & x1) | (s0 & r3) | (x1 & r3);
        x2        = c1 << 1;
        res.sum   = s1 ^ x2 ^ sgn;
        res.carry = (s1 & x2) | (s1 & sgn) | (x2 & sgn);
        return res;
    endfunction

endpackage

// File: rtl/booth_mult_sched_pp_gen.sv
// booth_pp_gen: Booth radix-4 encoder and partial-product generator.
// Ports:
//   a, b : signed operands (OP_W bits)
//   pp   : PP_N partial products, OP_W+1 bits each, already inverted for
//          negative digits (one's complement)
//   neg  : per-row sign bit; adding neg[j] at weight 4^j completes the
//          two's-complement negation
module booth_pp_gen
    import booth_mult_sched_pkg::*;
(
    input  logic [OP_W-1:0]            a,
    input  logic [OP_W-1:0]            b,
    output logic [PP_N-1:0][OP_W:0]    pp,
    output logic [PP_N-1:0]            neg
);

    logic [OP_W:0] b_ext;       // b with b[-1] = 0 appended
    booth_digit_e  digit [PP_N];
    logic [OP_W:0] mag   [PP_N];

    assign b_ext = {b, 1'b0};

    // ~mag read as signed OP_W+1 bits is exactly -mag-1, so even
    // -2 * -128 is exact once the neg bit is added.
    always_comb begin
        for (int unsigned j = 0; j < PP_N; j++) begin
            digit[j] = booth_decode(b_ext[2*j +: 3]);
            case (digit[j])
                P1, M1:  mag[j] = {a[OP_W-1], a};
                P2, M2:  mag[j] = {a, 1'b0};
                default: mag[j] = '0;
            endcase
            neg[j] = (digit[j] == M1) || (digit[j] == M2);
            pp[j]  = neg[j] ? ~mag[j] : mag[j];
        end
    end

endmodule

// File: rtl/booth_mult_sched.sv
// booth_mult_sched: two-requester round-robin front end feeding a
// two-stage Booth radix-4 signed 8x8 multiplier with valid/ready output.
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   req_valid[1:0], req_ready    : per-requester handshake (ready one-hot)
//   req_a0/b0/tag0, req_a1/b1/tag1 : operands and opaque tags
//   res_valid, res_ready         : result handshake
//   res_prod, res_src, res_tag   : product, winning requester, its tag
//   busy                         : stage 1 or output register occupied
module booth_mult_sched
    import booth_mult_sched_pkg::*;
#(
    parameter int unsigned TAG_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req_a0,
    input  logic [OP_W-1:0]   req_b0,
    input  logic [OP_W-1:0]   req_a1,
    input  logic [OP_W-1:0]   req_b1,
    input  logic [TAG_W-1:0]  req_tag0,
    input  logic [TAG_W-1:0]  req_tag1,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [PROD_W-1:0] res_prod,
    output logic              res_src,
    output logic [TAG_W-1:0]  res_tag,
    output logic              busy
);

    logic              last_q, last_d;
    logic              s1_valid_q, s1_valid_d;
    logic [PROD_W-1:0] s1_sum_q, s1_sum_d;
    logic [PROD_W-1:0] s1_carry_q, s1_carry_d;
    logic              s1_src_q, s1_src_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
    logic              res_valid_q, res_valid_d;
    logic [PROD_W-1:0] res_prod_q, res_prod_d;
    logic              res_src_q, res_src_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;

    logic              out_adv, s1_adv;
    logic              grant_any, grant_src, accept;
    logic [OP_W-1:0]   sel_a, sel_b;
    logic [TAG_W-1:0]  sel_tag;

    logic [PP_N-1:0][OP_W:0] pp;
    logic [PP_N-1:0]         neg;
    logic [PROD_W-1:0]       row [PP_N];
    logic [PROD_W-1:0]       sgn_vec;
    csa_t                    csa;

    assign out_adv = !res_valid_q || res_ready;
    assign s1_adv  = !s1_valid_q || out_adv;

    // last_q holds the requester served most recently; on contention the
    // other one wins.
    always_comb begin
        grant_any = 1'b0;
        grant_src = 1'b0;
        case (req_valid)
            2'b01: begin grant_any = 1'b1; grant_src = 1'b0;    end
            2'b10: begin grant_any = 1'b1; grant_src = 1'b1;    end
            2'b11: begin grant_any = 1'b1; grant_src = !last_q; end
            default: ;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (reset_n && grant_any && s1_adv) begin
            req_ready = grant_src ? 2'b10 : 2'b01;
        end
    end

    assign accept  = |req_ready;
    assign sel_a   = grant_src ? req_a1   : req_a0;
    assign sel_b   = grant_src ? req_b1   : req_b0;
    assign sel_tag = grant_src ? req_tag1 : req_tag0;

    booth_pp_gen u_pp_gen (
        .a   (sel_a),
        .b   (sel_b),
        .pp  (pp),
        .neg (neg)
    );

    // Sign-extend each row to product width and place it at weight 4^j.
    always_comb begin
        sgn_vec = '0;
        for (int unsigned j = 0; j < PP_N; j++) begin
            row[j] = {{(PROD_W-OP_W-1){pp[j][OP_W]}}, pp[j]} << (2*j);
            sgn_vec[2*j] = neg[j];
        end
    end

    assign csa = csa4_reduce(row[0], row[1], row[2], row[3], sgn_vec);

    always_comb begin
        last_d      = accept ? grant_src : last_q;

        s1_valid_d  = s1_valid_q;
        s1_sum_d    = s1_sum_q;
        s1_carry_d  = s1_carry_q;
        s1_src_d    = s1_src_q;
        s1_tag_d    = s1_tag_q;
        if (s1_adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_sum_d   = csa.sum;
                s1_carry_d = csa.carry;
                s1_src_d   = grant_src;
                s1_tag_d   = sel_tag;
            end
        end

        res_valid_d = res_valid_q;
        res_prod_d  = res_prod_q;
        res_src_d   = res_src_q;
        res_tag_d   = res_tag_q;
        if (out_adv) begin
            res_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_prod_d = s1_sum_q + (s1_carry_q << 1);
                res_src_d  = s1_src_q;
                res_tag_d  = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q      <= 1'b1;    // next contention goes to requester 0
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_carry_q  <= '0;
            s1_src_q    <= 1'b0;
            s1_tag_q    <= '0;
            res_valid_q <= 1'b0;
            res_prod_q  <= '0;
            res_src_q   <= 1'b0;
            res_tag_q   <= '0;
        end else begin
            last_q      <= last_d;
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_carry_q  <= s1_carry_d;
            s1_src_q    <= s1_src_d;
            s1_tag_q    <= s1_tag_d;
            res_valid_q <= res_valid_d;
            res_prod_q  <= res_prod_d;
            res_src_q   <= res_src_d;
            res_tag_q   <= res_tag_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_prod  = res_prod_q;
    assign res_src   = res_src_q;
    assign res_tag   = res_tag_q;
    assign busy      = s1_valid_q || res_valid_q;

endmodule

// File: tb/tb_booth_mult_sched.sv
// Directed bench for booth_mult_sched: reset state, single op latency,
// round-robin alternation, output stall/hold, reset flush, full sweep.
module tb_booth_mult_sched;

    localparam int unsigned TAG_W = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [7:0]       req_a0, req_b0, req_a1, req_b1;
    logic [TAG_W-1:0] req_tag0, req_tag1;
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_prod;
    logic             res_src;
    logic [TAG_W-1:0] res_tag;
    logic             busy;

    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;
    int unsigned n_total = 0;

    logic [17:0] sb [$];
    logic [17:0] exp_v;
    int unsigned idx;
    int unsigned cyc;
    int          sa, sbv, prod_i;

    always #5 clk = ~clk;

    booth_mult_sched #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_tag0  (req_tag0),
        .req_tag1  (req_tag1),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_prod  (res_prod),
        .res_src   (res_src),
        .res_tag   (res_tag),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 2'b00;
        res_ready = 1'b1;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        req_tag0 = '0; req_tag1 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        req_valid = 2'b11;
        #1;
        chk("rst_ready",  32'(req_ready), 32'h0);
        chk("rst_valid",  32'(res_valid), 32'h0);
        chk("rst_busy",   32'(busy),      32'h0);
        chk("rst_prod",   32'(res_prod),  32'h0);
        chk("rst_src",    32'(res_src),   32'h0);
        chk("rst_tag",    32'(res_tag),   32'h0);

        // Single op: 7 * -3 = -21
        @(negedge clk);
        reset_n = 1'b1; req_valid = 2'b01;
        req_a0 = 8'd7; req_b0 = 8'hFD; req_tag0 = 2'd2;
        #1;
        chk("one_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        chk("one_lat1_valid", 32'(res_valid), 32'h0);
        chk("one_lat1_busy",  32'(busy),      32'h1);
        @(negedge clk);
        chk("one_valid", 32'(res_valid), 32'h1);
        chk("one_prod",  32'(res_prod),  32'hFFEB);
        chk("one_src",   32'(res_src),   32'h0);
        chk("one_tag",   32'(res_tag),   32'h2);
        @(negedge clk);
        chk("one_drain_valid", 32'(res_valid), 32'h0);
        chk("one_drain_busy",  32'(busy),      32'h0);

        // Round robin from a fresh reset: -128*-128 and 127*-128
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        req_a0 = 8'h80; req_b0 = 8'h80; req_tag0 = 2'd1;
        req_a1 = 8'h7F; req_b1 = 8'h80; req_tag1 = 2'd3;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req_valid = (k < 4) ? 2'b11 : 2'b00;
            #1;
            if (k < 4) chk("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k >= 2) begin
                chk("rr_valid", 32'(res_valid), 32'h1);
                chk("rr_prod",  32'(res_prod), ((k - 2) % 2 == 0) ? 32'h4000 : 32'hC080);
                chk("rr_src",   32'(res_src),  ((k - 2) % 2 == 0) ? 32'h0 : 32'h1);
                chk("rr_tag",   32'(res_tag),  ((k - 2) % 2 == 0) ? 32'h1 : 32'h3);
            end
        end

        // Stall: 3*5=15, -2*9=-18, 10*-10=-100 with res_ready low 5 cycles
        @(negedge clk);
        res_ready = 1'b0; req_valid = 2'b01;
        req_a0 = 8'd3; req_b0 = 8'd5;
        #1;
        chk("stall_rdy0", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_a0 = 8'hFE; req_b0 = 8'd9;
        #1;
        chk("stall_rdy1", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_a0 = 8'd10; req_b0 = 8'hF6;
        #1;
        chk("stall_rdy2",   32'(req_ready), 32'h0);
        chk("stall_valid2", 32'(res_valid), 32'h1);
        chk("stall_prod2",  32'(res_prod),  32'h000F);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("stall_rdy_hold",   32'(req_ready), 32'h0);
            chk("stall_valid_hold", 32'(res_valid), 32'h1);
            chk("stall_prod_hold",  32'(res_prod),  32'h000F);
            chk("stall_busy_hold",  32'(busy),      32'h1);
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        chk("stall_release_rdy",  32'(req_ready), 32'h1);
        chk("stall_release_prod", 32'(res_prod),  32'h000F);
        @(negedge clk);
        req_valid = 2'b00;
        chk("stall_res_b_valid", 32'(res_valid), 32'h1);
        chk("stall_res_b",       32'(res_prod),  32'hFFEE);
        @(negedge clk);
        chk("stall_res_c_valid", 32'(res_valid), 32'h1);
        chk("stall_res_c",       32'(res_prod),  32'hFF9C);
        @(negedge clk);
        chk("stall_drain_valid", 32'(res_valid), 32'h0);
        chk("stall_drain_busy",  32'(busy),      32'h0);

        // Reset with two ops in flight; last served is requester 0
        req_valid = 2'b10; req_a1 = 8'd5; req_b1 = 8'd5;
        #1;
        chk("flush_rdy1", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = 2'b01; req_a0 = 8'd6; req_b0 = 8'd6;
        #1;
        chk("flush_rdy0", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 2'b11; reset_n = 1'b0;
        #1;
        chk("flush_inflight", 32'(busy),      32'h1);
        chk("flush_rst_rdy",  32'(req_ready), 32'h0);
        @(negedge clk);
        reset_n = 1'b1; req_a0 = 8'd2; req_b0 = 8'd3;
        #1;
        chk("flush_valid",  32'(res_valid), 32'h0);
        chk("flush_busy",   32'(busy),      32'h0);
        chk("flush_prod",   32'(res_prod),  32'h0);
        chk("flush_grant0", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        chk("flush_no_stale", 32'(res_valid), 32'h0);
        @(negedge clk);
        chk("flush_new_valid", 32'(res_valid), 32'h1);
        chk("flush_new_prod",  32'(res_prod),  32'h0006);
        chk("flush_new_src",   32'(res_src),   32'h0);
        @(negedge clk);
        chk("flush_new_drain", 32'(res_valid), 32'h0);

        // Exhaustive sweep through requester 1 with random backpressure
        idx = 0;
        cyc = 0;
        while ((idx < 65536 || sb.size() != 0 || res_valid) && cyc < 90000) begin
            @(negedge clk);
            cyc++;
            res_ready = ($urandom_range(15) != 0);
            if (idx < 65536) begin
                req_valid = 2'b10;
                req_a1    = idx[15:8];
                req_b1    = idx[7:0];
                req_tag1  = idx[1:0];
            end else begin
                req_valid = 2'b00;
            end
            #1;
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("sweep_spurious", 32'(res_valid), 32'h0);
                end else begin
                    exp_v = sb.pop_front();
                    chk("sweep_prod_tag", 32'({res_tag, res_prod}), 32'(exp_v));
                end
            end
            if (req_ready[1]) begin
                sa     = $signed(req_a1);
                sbv    = $signed(req_b1);
                prod_i = sa * sbv;
                sb.push_back({idx[1:0], prod_i[15:0]});
                idx++;
            end
        end
        chk("sweep_count",   32'(idx),       32'd65536);
        chk("sweep_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
